// File: rtl/rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rx_fifo_pkg
//  Brief    : Shared sizing constants and operation encoding for rx_fifo.
//  Revision : 1.0 - initial release
// ============================================================================
package rx_fifo_pkg;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 8;
   localparam int PTR_W  = 3;
   localparam int CNT_W  = 4;

   // Operation actually performed on a clock edge after gating the raw
   // requests against the current flags.
   typedef enum logic [1:0] {
      OP_IDLE  = 2'b00,
      OP_WRITE = 2'b01,
      OP_READ  = 2'b10,
      OP_BOTH  = 2'b11
   } op_e;

endpackage : rx_fifo_pkg
`default_nettype wire

// File: rtl/rx_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : rx_fifo_mem
//  Brief    : Register file with one synchronous write port, one asynchronous
//             read port and a synchronous clear of every entry.
//  Revision : 1.0 - initial release
// ============================================================================
module rx_fifo_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              i_clr,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Storage update: clear wins over a write so reset always leaves all zeros.
   always_ff @(posedge clk) begin
      if (i_clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule : rx_fifo_mem
`default_nettype wire

// File: rtl/rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : rx_fifo
//  Brief    : Single-clock first-word-fall-through FIFO. Head entry is always
//             visible on r_data; flags are decoded from a registered count.
//  Revision : 1.0 - initial release
// ============================================================================
module rx_fifo #(
   parameter int DATA_W = rx_fifo_pkg::DATA_W,
   parameter int DEPTH  = rx_fifo_pkg::DEPTH    // must be a power of two
) (
   input  logic              clk,
   input  logic              n_rst,     // synchronous, active-high
   input  logic              r_enable,
   input  logic              w_enable,
   input  logic [DATA_W-1:0] w_data,
   output logic [DATA_W-1:0] r_data,
   output logic              empty,
   output logic              full
);

   import rx_fifo_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;

   logic          w_do_wr;
   logic          w_do_rd;
   op_e           w_op;

   // A write is accepted unless full with no read freeing a slot; a read is
   // accepted only when something is stored (a read on empty is dropped even
   // if a write arrives in the same cycle).
   assign w_do_wr = w_enable & (~full | r_enable);
   assign w_do_rd = r_enable & ~empty;

   // Encode the accepted operation for the count update.
   always_comb begin
      w_op = OP_IDLE;
      case ({w_do_rd, w_do_wr})
         2'b01:   w_op = OP_WRITE;
         2'b10:   w_op = OP_READ;
         2'b11:   w_op = OP_BOTH;
         default: w_op = OP_IDLE;
      endcase
   end

   // Write pointer: power-of-two depth makes natural rollover the wrap.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         r_wptr <= '0;
      end else if (w_do_wr) begin
         r_wptr <= r_wptr + 1'b1;
      end
   end

   // Read pointer.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         r_rptr <= '0;
      end else if (w_do_rd) begin
         r_rptr <= r_rptr + 1'b1;
      end
   end

   // Occupancy count; simultaneous read and write leave it unchanged.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         r_count <= '0;
      end else begin
         case (w_op)
            OP_WRITE: r_count <= r_count + 1'b1;
            OP_READ:  r_count <= r_count - 1'b1;
            default:  r_count <= r_count;
         endcase
      end
   end

   // Flags come straight from the registered count, so they only move on
   // clock edges.
   assign empty = (r_count == '0);
   assign full  = (r_count == CW'(DEPTH));

   rx_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (AW)
   ) u_mem (
      .clk       (clk),
      .i_clr     (n_rst),
      .i_wr_en   (w_do_wr),
      .i_wr_addr (r_wptr),
      .i_wr_data (w_data),
      .i_rd_addr (r_rptr),
      .o_rd_data (r_data)
   );

endmodule : rx_fifo
`default_nettype wire

// File: tb/tb_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rx_fifo
//  Brief    : Directed self-checking bench for rx_fifo.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rx_fifo;

   logic       clk;
   logic       n_rst;
   logic       r_enable;
   logic       w_enable;
   logic [7:0] w_data;
   logic [7:0] r_data;
   logic       empty;
   logic       full;

   int n_tests = 0;
   int n_fail  = 0;

   rx_fifo #(
      .DATA_W (8),
      .DEPTH  (8)
   ) dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .r_enable (r_enable),
      .w_enable (w_enable),
      .w_data   (w_data),
      .r_data   (r_data),
      .empty    (empty),
      .full     (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      w_enable = 1'b1;
      w_data   = d;
      tick();
      w_enable = 1'b0;
   endtask

   task automatic pop();
      r_enable = 1'b1;
      tick();
      r_enable = 1'b0;
   endtask

   task automatic push_pop(input logic [7:0] d);
      w_enable = 1'b1;
      r_enable = 1'b1;
      w_data   = d;
      tick();
      w_enable = 1'b0;
      r_enable = 1'b0;
   endtask

   task automatic do_reset();
      n_rst = 1'b1;
      tick();
      n_rst = 1'b0;
   endtask

   logic [7:0] pat [8];

   initial begin
      n_rst    = 1'b1;
      r_enable = 1'b0;
      w_enable = 1'b0;
      w_data   = 8'h00;
      tick();
      n_rst = 1'b0;

      // Reset state
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full",  32'(full),  32'd0);
      chk("rst_rdata", 32'(r_data), 32'h00);

      // Single write then read
      push(8'hFF);
      chk("w1_rdata", 32'(r_data), 32'hFF);
      chk("w1_empty", 32'(empty), 32'd0);
      chk("w1_full",  32'(full),  32'd0);
      pop();
      chk("r1_empty", 32'(empty), 32'd1);

      // Read on empty is ignored
      pop();
      chk("rempty_empty", 32'(empty), 32'd1);
      chk("rempty_full",  32'(full),  32'd0);
      // Push one marker and confirm the dropped read did not move rptr
      push(8'h3C);
      chk("rempty_rptr", 32'(r_data), 32'h3C);
      pop();
      chk("rempty_drain", 32'(empty), 32'd1);

      // Simultaneous read+write on empty: only the write takes effect
      push(8'h77);
      pop();
      push_pop(8'h00);
      chk("rw_empty_empty", 32'(empty), 32'd0);
      chk("rw_empty_rdata", 32'(r_data), 32'h00);
      pop();
      chk("rw_empty_drain", 32'(empty), 32'd1);

      // Fill to full, overflow attempts, then drain in order
      pat[0] = 8'hFF; pat[1] = 8'hFF; pat[2] = 8'h00; pat[3] = 8'h00;
      pat[4] = 8'hFF; pat[5] = 8'h00; pat[6] = 8'h00; pat[7] = 8'h00;
      for (int i = 0; i < 8; i++) begin
         push(pat[i]);
         chk($sformatf("fill_full_%0d", i), 32'(full), (i == 7) ? 32'd1 : 32'd0);
      end
      push(8'hFF);
      push(8'hFF);
      chk("ovf_full",  32'(full), 32'd1);
      chk("ovf_head",  32'(r_data), 32'hFF);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain_%0d", i), 32'(r_data), 32'(pat[i]));
         pop();
      end
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_full",  32'(full),  32'd0);

      // Alternating single write/read, repeated to walk pointers past the wrap
      pat[0] = 8'hFF; pat[1] = 8'hFF; pat[2] = 8'h00; pat[3] = 8'h00;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 4; i++) begin
            push(pat[i] ^ 8'(r));
            chk($sformatf("alt_%0d_%0d", r, i), 32'(r_data), 32'(pat[i] ^ 8'(r)));
            pop();
            chk($sformatf("alt_empty_%0d_%0d", r, i), 32'(empty), 32'd1);
         end
      end

      // Full with simultaneous read+write: oldest replaced, A5 comes out last
      for (int i = 0; i < 8; i++) begin
         push(8'h10 + 8'(i));
      end
      chk("pre_both_full", 32'(full), 32'd1);
      push_pop(8'hA5);
      chk("both_full_full", 32'(full), 32'd1);
      chk("both_full_head", 32'(r_data), 32'h11);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("both_drain_%0d", i), 32'(r_data), (i == 7) ? 32'hA5 : 32'(8'h11 + 8'(i)));
         pop();
      end
      chk("both_drain_empty", 32'(empty), 32'd1);

      // Reset with 5 entries held; enables during reset must be ignored
      for (int i = 0; i < 5; i++) begin
         push(8'h31 + 8'(i));
      end
      chk("pre_rst_head", 32'(r_data), 32'h31);
      w_enable = 1'b1;
      r_enable = 1'b1;
      w_data   = 8'hEE;
      do_reset();
      w_enable = 1'b0;
      r_enable = 1'b0;
      chk("mid_rst_empty", 32'(empty), 32'd1);
      chk("mid_rst_full",  32'(full),  32'd0);
      chk("mid_rst_rdata", 32'(r_data), 32'h00);
      push(8'h5A);
      chk("post_rst_rdata", 32'(r_data), 32'h5A);
      chk("post_rst_empty", 32'(empty), 32'd0);
      pop();
      chk("post_rst_drain", 32'(empty), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_rx_fifo
`default_nettype wire
